regfile_2r1w: RTL

- Parametrised register file for the ALU datapath: one synchronous write port and two independent synchronous read ports (A, B) feeding the two ALU operands.
- Generalises the fixed 16x32 two-port lookup to configurable width and depth, with registered reads, write-to-read bypass and a hardware clear engine.
- After reset or a clear request, it zero-fills every entry before accepting traffic.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_if.sv | 33 +++
 rtl/regfile_clear_fsm.sv | 66 ++++++
 rtl/regfile_2r1w.sv | 85 ++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, state encoding and bypass-compare helper for the 2R1W register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int CMP_W      = 16;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Addresses are widened to CMP_W so one helper serves any ADDR_W up to CMP_W.
  function automatic logic bypass_hit(input logic             wr_en,
                                      input logic             rd_en,
                                      input logic [CMP_W-1:0] wr_addr,
                                      input logic [CMP_W-1:0] rd_addr);
    return wr_en && rd_en && (wr_addr == rd_addr);
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Access bus of the 2R1W register file: one write port, two read ports, clear request and busy.
interface regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) ();

  logic              clr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en_a;
  logic [ADDR_W-1:0] addressA;
  logic [DATA_W-1:0] dataA;
  logic              valid_a;
  logic              rd_en_b;
  logic [ADDR_W-1:0] addressB;
  logic [DATA_W-1:0] dataB;
  logic              valid_b;
  logic              busy;

  modport master (
    output clr, wr_en, wr_addr, wr_data,
    output rd_en_a, addressA, rd_en_b, addressB,
    input  dataA, valid_a, dataB, valid_b, busy
  );

  modport slave (
    input  clr, wr_en, wr_addr, wr_data,
    input  rd_en_a, addressA, rd_en_b, addressB,
    output dataA, valid_a, dataB, valid_b, busy
  );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Clear engine: walks a pointer over every entry after reset or clr, then hands the array to traffic.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  output logic              o_busy,
  output logic              o_ready,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;

  // NOTE: state lives only in clocked blocks written with <=, so every reader sees the pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // NOTE: defaults first so no path leaves a comb output unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_CLEAR: begin
        w_ptr_nxt = r_ptr + ADDR_W'(1);
        if (r_ptr == PTR_LAST) begin
          w_state_nxt = ST_READY;
          w_ptr_nxt   = '0;
        end
      end
      ST_READY: begin
        if (i_clr) begin
          w_state_nxt = ST_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    o_ready    = (r_state == ST_READY);
    o_busy     = !o_ready;
    o_clr_we   = (r_state == ST_CLEAR);
    o_clr_addr = r_ptr;
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Parametrised register file, 1 write / 2 registered read ports with write-to-read bypass.
// Build option: define ZERO_REG_EN to hardwire entry 0 to zero.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic      clk,
  input logic      rst,
  regfile_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_data_a, r_data_b;
  logic              r_valid_a, r_valid_b;
  logic [DATA_W-1:0] w_rd_a, w_rd_b;
  logic              w_ready, w_busy, w_clr_we, w_user_we;
  logic [ADDR_W-1:0] w_clr_addr;

  regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (bus.clr),
    .o_busy     (w_busy),
    .o_ready    (w_ready),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

`ifdef ZERO_REG_EN
  assign w_user_we = w_ready && bus.wr_en && (bus.wr_addr != '0);
`else
  assign w_user_we = w_ready && bus.wr_en;
`endif

  // NOTE: the array has no reset branch; it is zeroed by the clear engine so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_user_we) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    w_rd_a = r_mem[bus.addressA];
    w_rd_b = r_mem[bus.addressB];
    if (bypass_hit(bus.wr_en, bus.rd_en_a, CMP_W'(bus.wr_addr), CMP_W'(bus.addressA)))
      w_rd_a = bus.wr_data;
    if (bypass_hit(bus.wr_en, bus.rd_en_b, CMP_W'(bus.wr_addr), CMP_W'(bus.addressB)))
      w_rd_b = bus.wr_data;
`ifdef ZERO_REG_EN
    if (bus.addressA == '0) w_rd_a = '0;
    if (bus.addressB == '0) w_rd_b = '0;
`endif
  end

  // Read data holds whenever no read is accepted, including throughout a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_a  <= '0;
      r_data_b  <= '0;
      r_valid_a <= 1'b0;
      r_valid_b <= 1'b0;
    end else if (w_ready) begin
      r_valid_a <= bus.rd_en_a;
      r_valid_b <= bus.rd_en_b;
      if (bus.rd_en_a) r_data_a <= w_rd_a;
      if (bus.rd_en_b) r_data_b <= w_rd_b;
    end else begin
      r_valid_a <= 1'b0;
      r_valid_b <= 1'b0;
    end
  end

  assign bus.dataA   = r_data_a;
  assign bus.dataB   = r_data_b;
  assign bus.valid_a = r_valid_a;
  assign bus.valid_b = r_valid_b;
  assign bus.busy    = w_busy;

endmodule
